// File: rtl/demux_pkg.sv
// Shared constants and helpers for the 1-to-N buffered demultiplexer.
//   DEF_*          default parameter values for demux_1tn_buf
//   DEF_DROP_SAT   saturation value of the drop counter at default width
//   sel_in_range   1 when a select value addresses an existing channel
package demux_pkg;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_CHANNELS = 4;
  localparam int DEF_CNT_W    = 8;

  localparam logic [DEF_CNT_W-1:0] DEF_DROP_SAT = {DEF_CNT_W{1'b1}};

  function automatic logic sel_in_range(input int unsigned sel,
                                        input int unsigned channels);
    return sel < channels;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output buffer for a single demux channel.
//   clk, rst   clock, synchronous active-high reset
//   load       write d into the slot this edge (wins over a drain)
//   d          word to store
//   out_ready  consumer accepts the held word this cycle
//   out_valid  slot holds a word
//   out_data   held word; holds last value after draining
//   free       slot can take a word this edge (empty or draining now)
module demux_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             free
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  // A slot being drained this cycle may be refilled in the same edge,
  // which is what gives one word per cycle per channel.
  assign free      = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= d;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_1tn_buf.sv
// Registered 1-to-N demultiplexer with per-channel one-entry buffers.
//   clk, rst    clock, synchronous active-high reset
//   in_valid    producer has a word
//   in_ready    word accepted when in_valid && in_ready
//   in_sel      target channel; values >= CHANNELS are dropped
//   in_bcast    deliver to every channel (all-or-nothing), in_sel ignored
//   in_data     data word
//   out_valid   per-channel word present
//   out_ready   per-channel consumer ready
//   out_data    flattened channel data, channel i at [i*WIDTH +: WIDTH]
//   err_sel     sticky: an out-of-range select was accepted
//   drop_cnt    saturating count of dropped words
module demux_1tn_buf
  import demux_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int SEL_W    = $clog2(CHANNELS),
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_bcast,
  input  logic [WIDTH-1:0]          in_data,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic                      err_sel,
  output logic [CNT_W-1:0]          drop_cnt
);

  localparam int                 SEL_N    = 1 << SEL_W;
  localparam logic [CNT_W-1:0]   DROP_SAT = {CNT_W{1'b1}};

  logic [CHANNELS-1:0]             free;
  logic [CHANNELS-1:0]             load;
  logic [CHANNELS-1:0][WIDTH-1:0]  data_arr;
  logic [SEL_N-1:0]                free_ext;
  logic                            in_range;
  logic                            accept;
  logic                            drop;

  assign in_range = sel_in_range(int'(in_sel), CHANNELS);

  // Zero-extend free to the full select range so indexing by in_sel is
  // always in bounds; out-of-range entries are never consulted.
  always_comb begin
    free_ext                 = '0;
    free_ext[CHANNELS-1:0]   = free;
  end

  always_comb begin
    in_ready = 1'b1;
    if (in_bcast)      in_ready = &free;
    else if (in_range) in_ready = free_ext[in_sel];
  end

  assign accept = in_valid && in_ready;
  assign drop   = accept && !in_bcast && !in_range;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_slot
      assign load[gi] = accept && (in_bcast || (in_range && in_sel == SEL_W'(gi)));

      demux_slot #(.WIDTH(WIDTH)) u_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (load[gi]),
        .d         (in_data),
        .out_ready (out_ready[gi]),
        .out_valid (out_valid[gi]),
        .out_data  (data_arr[gi]),
        .free      (free[gi])
      );
    end
  endgenerate

  assign out_data = data_arr;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_sel  <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      err_sel <= 1'b1;
      if (drop_cnt != DROP_SAT) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_demux_1tn_buf.sv
module tb_demux_1tn_buf;

  logic         clk = 1'b0;
  logic         rst = 1'b0;

  // 4-channel instance
  logic         in_valid = 1'b0, in_bcast = 1'b0, in_ready;
  logic [1:0]   in_sel = '0;
  logic [31:0]  in_data = '0;
  logic [3:0]   out_valid, out_ready = '0;
  logic [127:0] out_data;
  logic         err_sel;
  logic [7:0]   drop_cnt;

  // 3-channel instance for out-of-range selects
  logic         v3 = 1'b0, b3 = 1'b0, rdy3;
  logic [1:0]   sel3 = '0;
  logic [31:0]  d3 = '0;
  logic [2:0]   ov3, or3 = '0;
  logic [95:0]  od3;
  logic         err3;
  logic [7:0]   cnt3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  demux_1tn_buf #(.WIDTH(32), .CHANNELS(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_bcast(in_bcast), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .err_sel(err_sel), .drop_cnt(drop_cnt)
  );

  demux_1tn_buf #(.WIDTH(32), .CHANNELS(3), .CNT_W(8)) dut3 (
    .clk(clk), .rst(rst), .in_valid(v3), .in_ready(rdy3),
    .in_sel(sel3), .in_bcast(b3), .in_data(d3),
    .out_valid(ov3), .out_ready(or3), .out_data(od3),
    .err_sel(err3), .drop_cnt(cnt3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (out_valid !== 4'b0000) begin
      failures++; $display("FAIL reset_out_valid got=%b exp=0000", out_valid);
    end
    checks++;
    if (out_data !== 128'h0) begin
      failures++; $display("FAIL reset_out_data got=%h exp=0", out_data);
    end
    checks++;
    if (err_sel !== 1'b0 || drop_cnt !== 8'd0 || err3 !== 1'b0 || cnt3 !== 8'd0) begin
      failures++; $display("FAIL reset_err got=%b/%0d/%b/%0d exp=0", err_sel, drop_cnt, err3, cnt3);
    end
  endtask

  task automatic test_unicast();
    out_ready = 4'b0000;
    in_valid = 1'b1; in_sel = 2'd2; in_data = 32'hDEADBEEF;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL unicast_ready got=%b exp=1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 4'b0100) begin
      failures++; $display("FAIL unicast_valid got=%b exp=0100", out_valid);
    end
    checks++;
    if (out_data !== {32'h0, 32'hDEADBEEF, 32'h0, 32'h0}) begin
      failures++; $display("FAIL unicast_data got=%h", out_data);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 4'b1111;
    tick();
    out_ready = 4'b0000;
    in_valid = 1'b1; in_sel = 2'd1; in_data = 32'hAAAA0001;
    tick();
    in_data = 32'hBBBB0002;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL bp_ready_low got=%b exp=0", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 4'b0010 || out_data[63:32] !== 32'hAAAA0001) begin
      failures++; $display("FAIL bp_hold got=%b/%h exp=0010/aaaa0001", out_valid, out_data[63:32]);
    end
    out_ready = 4'b0010;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_ready_high got=%b exp=1", in_ready);
    end
    tick();
    in_valid = 1'b0; out_ready = 4'b0000;
    checks++;
    if (out_valid !== 4'b0010 || out_data[63:32] !== 32'hBBBB0002) begin
      failures++; $display("FAIL bp_refill got=%b/%h exp=0010/bbbb0002", out_valid, out_data[63:32]);
    end
  endtask

  task automatic test_broadcast();
    in_valid = 1'b1; in_sel = 2'd3; in_data = 32'h33333333;
    tick();
    in_sel = 2'd0; in_bcast = 1'b1; in_data = 32'h12345678;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL bcast_ready_low got=%b exp=0", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 4'b1010 || out_data[127:96] !== 32'h33333333 || out_data[31:0] !== 32'h0) begin
      failures++; $display("FAIL bcast_no_partial got=%b/%h", out_valid, out_data);
    end
    out_ready = 4'b1010;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL bcast_ready_high got=%b exp=1", in_ready);
    end
    tick();
    in_valid = 1'b0; in_bcast = 1'b0; out_ready = 4'b0000;
    checks++;
    if (out_valid !== 4'b1111 || out_data !== {4{32'h12345678}}) begin
      failures++; $display("FAIL bcast_load got=%b/%h", out_valid, out_data);
    end
  endtask

  task automatic test_streaming();
    logic [31:0] ch;
    logic [3:0]  exp_v;
    out_ready = 4'b1111;
    tick();
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; in_sel = 2'(k % 4); in_data = 32'(k + 1);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        failures++; $display("FAIL stream_ready k=%0d got=%b exp=1", k, in_ready);
      end
      tick();
      exp_v = 4'b0001 << (k % 4);
      ch = out_data[(k % 4)*32 +: 32];
      checks++;
      if (out_valid !== exp_v || ch !== 32'(k + 1)) begin
        failures++; $display("FAIL stream_word k=%0d got=%b/%0d exp=%b/%0d", k, out_valid, ch, exp_v, k + 1);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 4'b0000) begin
      failures++; $display("FAIL stream_drain got=%b exp=0000", out_valid);
    end
    out_ready = 4'b0000;
  endtask

  task automatic test_out_of_range();
    int bad_rdy = 0;
    or3 = 3'b000;
    v3 = 1'b1; sel3 = 2'd3; d3 = 32'hFEEDF00D;
    #1;
    checks++;
    if (rdy3 !== 1'b1) begin
      failures++; $display("FAIL oor_ready got=%b exp=1", rdy3);
    end
    tick();
    checks++;
    if (cnt3 !== 8'd1 || err3 !== 1'b1) begin
      failures++; $display("FAIL oor_first got=%0d/%b exp=1/1", cnt3, err3);
    end
    for (int k = 1; k < 300; k++) begin
      if (rdy3 !== 1'b1) bad_rdy++;
      tick();
    end
    v3 = 1'b0;
    checks++;
    if (bad_rdy != 0) begin
      failures++; $display("FAIL oor_ready_stream got=%0d low cycles exp=0", bad_rdy);
    end
    checks++;
    if (cnt3 !== 8'd255 || err3 !== 1'b1) begin
      failures++; $display("FAIL oor_saturate got=%0d/%b exp=255/1", cnt3, err3);
    end
    checks++;
    if (ov3 !== 3'b000 || od3 !== 96'h0) begin
      failures++; $display("FAIL oor_no_load got=%b/%h exp=000/0", ov3, od3);
    end
  endtask

  task automatic test_mid_reset();
    out_ready = 4'b0000;
    in_valid = 1'b1; in_sel = 2'd0; in_data = 32'h0000000A;
    tick();
    in_sel = 2'd2; in_data = 32'h0000000C;
    tick();
    checks++;
    if (out_valid[0] !== 1'b1 || out_valid[2] !== 1'b1) begin
      failures++; $display("FAIL mreset_setup got=%b", out_valid);
    end
    rst = 1'b1; in_sel = 2'd1; in_data = 32'h99999999;
    v3 = 1'b1; sel3 = 2'd3;
    tick();
    rst = 1'b0; in_valid = 1'b0; v3 = 1'b0;
    checks++;
    if (out_valid !== 4'b0000 || out_data !== 128'h0) begin
      failures++; $display("FAIL mreset_clear got=%b/%h exp=0/0", out_valid, out_data);
    end
    checks++;
    if (err3 !== 1'b0 || cnt3 !== 8'd0 || err_sel !== 1'b0 || drop_cnt !== 8'd0) begin
      failures++; $display("FAIL mreset_err got=%b/%0d exp=0/0", err3, cnt3);
    end
    tick();
    checks++;
    if (out_valid !== 4'b0000) begin
      failures++; $display("FAIL mreset_no_capture got=%b exp=0000", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_backpressure();
    test_broadcast();
    test_streaming();
    test_out_of_range();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux_1tn_buf.md
Name: demux_1tn_buf

Overview:
- Parametrised, registered 1-to-N demultiplexer with a valid/ready handshake on each side.
- Routes one WIDTH-bit word per cycle from a single producer to one of CHANNELS consumers, or to all of them in broadcast mode.
- Each channel has a one-entry output buffer, so each consumer can apply backpressure independently.
- Sits between the superscalar issue/writeback stages and per-lane consumers, replacing fixed combinational 32-bit 1-to-4 demux trees.

Parameters:
- WIDTH, 32, data word width in bits.
- CHANNELS, 4, number of output channels (2..16).
- SEL_W, $clog2(CHANNELS), select width; derived, not overridden.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a word.
- in_ready  output  1  word accepted this cycle when in_valid && in_ready.
- in_sel  input  SEL_W  target channel index.
- in_bcast  input  1  broadcast to all channels; in_sel ignored.
- in_data  input  WIDTH  data word.
- out_valid  output  CHANNELS  per-channel buffer holds a word.
- out_ready  input  CHANNELS  per-channel consumer ready.
- out_data  output  CHANNELS*WIDTH  flattened channel data; channel i at bits [i*WIDTH +: WIDTH].
- err_sel  output  1  sticky flag: an out-of-range select was accepted.
- drop_cnt  output  CNT_W  saturating count of dropped words.

Behaviour:
- Reset (rst=1 at a clock edge): all out_valid=0, all out_data=0, err_sel=0, drop_cnt=0. Reset mid-transfer discards every buffered word; no partial state survives.
- Per-channel state: valid_q[i], data_q[i].
  - free[i] = !valid_q[i] || out_ready[i], so a slot draining this cycle counts as free.
- Ready:
  - in_bcast=1: in_ready = AND of all free[i].
  - in_bcast=0, in_sel < CHANNELS: in_ready = free[in_sel].
  - in_bcast=0, in_sel >= CHANNELS: in_ready = 1 (drop path).
  - in_ready is combinational from out_ready and state; it does not depend on in_valid.
- Accept, unicast (in_sel < CHANNELS): at the edge, data_q[in_sel] <= in_data and valid_q[in_sel] <= 1.
- Accept, broadcast: every channel loads in_data and sets valid in the same edge. Broadcast is all-or-nothing; a partial broadcast never occurs.
- Accept, out-of-range select: no channel is loaded, err_sel <= 1 (sticky until rst), and drop_cnt increments, saturating at 2^CNT_W-1.
- Drain: when valid_q[i] && out_ready[i] and no load to channel i, valid_q[i] <= 0. data_q[i] holds its last value.
- Simultaneous drain and load on one channel: the load wins, valid_q stays 1 and data_q takes the new word, giving full throughput of 1 word/cycle per channel.
- Latency: a word accepted at edge k is visible on out_data/out_valid after edge k (1 cycle). There is no combinational in-to-out data path.
- out_data[i] is stable while out_valid[i]=1 && out_ready[i]=0.
- out_valid never deasserts without a handshake, except on rst.
- in_valid=0: no state change except drains.

Decomposition:
- Shared package demux_pkg holds:
  - the default WIDTH/CHANNELS/CNT_W constants;
  - a sel_in_range function (sel < CHANNELS);
  - the localparam for drop-counter saturation value.
- Natural sub-module demux_slot: one-entry buffer (clk, rst, load, d, out_ready, out_valid, out_data, free), instantiated CHANNELS times in a generate loop.
- The top level holds the ready/select logic, the error flag and the drop counter.

Test Plan:
- Reset then unicast: rst 2 cycles; in_sel=2, in_data=32'hDEADBEEF, in_valid=1 one cycle, out_ready=4'b0000 -> next cycle out_valid=4'b0100, channel 2 data=DEADBEEF, others 0.
- Backpressure: channel 1 full with out_ready[1]=0; send to sel=1 -> in_ready=0 and the word is held. Raise out_ready[1] -> in_ready=1 in the same cycle; after the edge, channel 1 holds the new word with out_valid[1]=1 throughout.
- Broadcast: channel 3 full and stalled, in_bcast=1, in_data=32'h12345678 -> in_ready=0 and no channel loads. Release channel 3 -> one edge loads all four, out_valid=4'b1111.
- Streaming: out_ready=4'b1111, sel cycling 0,1,2,3 with data 1..8 back-to-back -> in_ready stays 1, each channel shows its words in order with 1-cycle latency and no gaps or duplicates.
- Out-of-range select: CHANNELS=3 build, in_sel=3 accepted 300 times -> in_ready=1, no out_valid change, err_sel=1, drop_cnt saturates at 255.
- Mid-stream reset: channels 0 and 2 valid; assert rst one cycle with in_valid=1 -> after the edge, out_valid=0, err_sel=0, drop_cnt=0, and the input word is not captured.
